// File: rtl/spi_boot_loader.sv
// SPI mode-0 READ (0x03) engine: streams byte_len flash bytes into a memory write port.
// CS low for (32+8N)*2*CLK_DIV + CLK_DIV cycles; no backpressure, one strobe per 16*CLK_DIV cycles.
module spi_boot_loader #(
  parameter int CLK_DIV = 2,
  parameter int MEM_AW  = 10
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              start,
  input  logic [23:0]       flash_addr,
  input  logic [15:0]       byte_len,
  output logic              busy,
  output logic              done,
  input  logic              MISO,
  output logic              MOSI,
  output logic              SCLK,
  output logic              CS,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, FIN} state_t;

  state_t            r_state;
  logic              r_busy, r_done, r_mosi, r_sclk, r_cs, r_we, r_pend;
  logic [MEM_AW-1:0] r_addr;
  logic [7:0]        r_wdata, r_rx, r_div;
  logic [31:0]       r_tx;
  logic [19:0]       r_bit, r_last;
  logic              w_div_end;
  logic              w_byte_end;

  assign w_div_end  = (r_div == 8'(CLK_DIV - 1));
  // Header is 32 bits, a multiple of 8, so the low bits of r_bit mark byte ends.
  assign w_byte_end = (r_bit >= 20'd32) && (r_bit[2:0] == 3'd7);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mosi  <= 1'b0;
      r_sclk  <= 1'b0;
      r_cs    <= 1'b1;
      r_we    <= 1'b0;
      r_pend  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rx    <= '0;
      r_div   <= '0;
      r_tx    <= '0;
      r_bit   <= '0;
      r_last  <= '0;
    end else begin
      r_we   <= r_pend;
      r_pend <= 1'b0;
      if (r_pend) r_wdata <= r_rx;
      if (r_we)   r_addr  <= r_addr + 1'b1;
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_addr <= '0;
            if (byte_len != 16'd0) begin
              r_state <= SHIFT;
              r_busy  <= 1'b1;
              r_cs    <= 1'b0;
              r_sclk  <= 1'b0;
              r_mosi  <= 1'b0;
              r_tx    <= {8'h03, flash_addr};
              r_bit   <= '0;
              r_div   <= '0;
              r_last  <= 20'({byte_len, 3'b000}) + 20'd31;
            end else begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (w_div_end) begin
            r_div <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
              r_rx   <= {r_rx[6:0], MISO};
              if (w_byte_end) r_pend <= 1'b1;
            end else begin
              r_sclk <= 1'b0;
              if (r_bit == r_last) begin
                r_state <= HOLD;
                r_mosi  <= 1'b0;
              end else begin
                r_bit  <= r_bit + 20'd1;
                r_tx   <= {r_tx[30:0], 1'b0};
                r_mosi <= r_tx[30];
              end
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        HOLD: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_state <= FIN;
            r_cs    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign MOSI      = r_mosi;
  assign SCLK      = r_sclk;
  assign CS        = r_cs;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_spi_boot_loader.sv
// Directed bench: u0 runs CLK_DIV=2/MEM_AW=10, u1 runs CLK_DIV=1/MEM_AW=2, each with a flash model.
module tb_spi_boot_loader;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [23:0] flash_addr = '0;
  logic [15:0] byte_len = '0;

  logic       busy0, done0, MISO0, MOSI0, SCLK0, CS0, mem_we0;
  logic [9:0] mem_addr0;
  logic [7:0] mem_wdata0;
  logic       busy1, done1, MISO1, MOSI1, SCLK1, CS1, mem_we1;
  logic [1:0] mem_addr1;
  logic [7:0] mem_wdata1;

  spi_boot_loader #(.CLK_DIV(2), .MEM_AW(10)) u0 (
    .clk_in(clk_in), .rst(rst), .start(start0), .flash_addr(flash_addr), .byte_len(byte_len),
    .busy(busy0), .done(done0), .MISO(MISO0), .MOSI(MOSI0), .SCLK(SCLK0), .CS(CS0),
    .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0));

  spi_boot_loader #(.CLK_DIV(1), .MEM_AW(2)) u1 (
    .clk_in(clk_in), .rst(rst), .start(start1), .flash_addr(flash_addr), .byte_len(byte_len),
    .busy(busy1), .done(done1), .MISO(MISO1), .MOSI(MOSI1), .SCLK(SCLK1), .CS(CS1),
    .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Flash model: header bits read back as 1 (must be discarded), then fbytes MSB first.
  logic [7:0] fbytes [8];
  int rcnt0 = 0, rcnt1 = 0;
  logic [31:0] mosi_cap0 = '0, mosi_cap1 = '0;

  function automatic logic miso_bit(input int r);
    int idx;
    if (r < 32) return 1'b1;
    idx = (r - 32) >> 3;
    if (idx > 7) return 1'b0;
    return fbytes[idx][7 - ((r - 32) & 7)];
  endfunction

  assign MISO0 = miso_bit(rcnt0);
  assign MISO1 = miso_bit(rcnt1);

  always @(posedge SCLK0 or posedge CS0) begin
    if (CS0) rcnt0 <= 0;
    else begin
      if (rcnt0 < 32) mosi_cap0 <= {mosi_cap0[30:0], MOSI0};
      rcnt0 <= rcnt0 + 1;
    end
  end

  always @(posedge SCLK1 or posedge CS1) begin
    if (CS1) rcnt1 <= 0;
    else begin
      if (rcnt1 < 32) mosi_cap1 <= {mosi_cap1[30:0], MOSI1};
      rcnt1 <= rcnt1 + 1;
    end
  end

  int wa0[$], wt0[$], wa1[$];
  logic [7:0] wd0[$], wd1[$];
  int cs_lo0, sclk_hi0, done_n0, ovl0, cs_lo1, sclk_hi1, done_n1, ovl1;

  always @(negedge clk_in) begin
    if (mem_we0 === 1'b1) begin wa0.push_back(int'(mem_addr0)); wd0.push_back(mem_wdata0); wt0.push_back(cyc); end
    if (mem_we1 === 1'b1) begin wa1.push_back(int'(mem_addr1)); wd1.push_back(mem_wdata1); end
    if (CS0 === 1'b0) cs_lo0++;
    if (SCLK0 === 1'b1) sclk_hi0++;
    if (done0 === 1'b1) done_n0++;
    if (done0 === 1'b1 && busy0 === 1'b1) ovl0++;
    if (CS1 === 1'b0) cs_lo1++;
    if (SCLK1 === 1'b1) sclk_hi1++;
    if (done1 === 1'b1) done_n1++;
    if (done1 === 1'b1 && busy1 === 1'b1) ovl1++;
  end

  task automatic clear_mon();
    wa0.delete(); wd0.delete(); wt0.delete(); wa1.delete(); wd1.delete();
    cs_lo0 = 0; sclk_hi0 = 0; done_n0 = 0; ovl0 = 0;
    cs_lo1 = 0; sclk_hi1 = 0; done_n1 = 0; ovl1 = 0;
  endtask

  // Returns at the negedge of the first cycle after the accepting edge.
  task automatic pulse(input int sel, input logic [23:0] a, input logic [15:0] n);
    @(negedge clk_in);
    flash_addr = a;
    byte_len   = n;
    if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk_in);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int sel, input int budget);
    int k;
    k = 0;
    while (((sel == 1) ? done1 : done0) !== 1'b1 && k < budget) begin
      @(negedge clk_in);
      k++;
    end
    n_cmp++;
    if (((sel == 1) ? done1 : done0) !== 1'b1) begin
      n_bad++;
      $display("FAIL done_timeout dut%0d: no done within %0d cycles", sel, budget);
    end
    repeat (3) @(negedge clk_in);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk_in);
    n_cmp++;
    if ({busy0, done0, CS0, SCLK0, MOSI0, mem_we0} !== 6'b001000) begin
      n_bad++; $display("FAIL reset_ctl0: got %b want 001000", {busy0, done0, CS0, SCLK0, MOSI0, mem_we0});
    end
    n_cmp++;
    if ({mem_addr0, mem_wdata0} !== 18'h0) begin
      n_bad++; $display("FAIL reset_mem0: got %h want 0", {mem_addr0, mem_wdata0});
    end
    n_cmp++;
    if ({busy1, done1, CS1, SCLK1, MOSI1, mem_we1, mem_addr1, mem_wdata1} !== 16'h2000) begin
      n_bad++; $display("FAIL reset_u1: got %h want 2000", {busy1, done1, CS1, SCLK1, MOSI1, mem_we1, mem_addr1, mem_wdata1});
    end
    rst = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_main_read();
    logic [7:0] exp_d [4];
    int k;
    exp_d = '{8'hA5, 8'h5A, 8'hFF, 8'h00};
    fbytes = '{8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    clear_mon();
    pulse(0, 24'h012345, 16'd4);
    n_cmp++;
    if ({busy0, CS0, SCLK0, MOSI0} !== 4'b1000) begin
      n_bad++; $display("FAIL start_t1: got %b want 1000", {busy0, CS0, SCLK0, MOSI0});
    end
    k = 0;
    while (SCLK0 !== 1'b1 && k < 20) begin @(negedge clk_in); k++; end
    n_cmp++;
    if (k !== 2) begin n_bad++; $display("FAIL first_rise: got %0d want 2 cycles after T+1", k); end
    wait_done(0, 2000);
    n_cmp++;
    if (mosi_cap0 !== 32'h03012345) begin n_bad++; $display("FAIL mosi_hdr: got %h want 03012345", mosi_cap0); end
    n_cmp++;
    if (wa0.size() !== 4) begin n_bad++; $display("FAIL we_count: got %0d want 4", wa0.size()); end
    for (int i = 0; i < 4 && i < wa0.size(); i++) begin
      n_cmp++;
      if (wa0[i] !== i || wd0[i] !== exp_d[i]) begin
        n_bad++; $display("FAIL write%0d: got (%0d,%h) want (%0d,%h)", i, wa0[i], wd0[i], i, exp_d[i]);
      end
    end
    for (int i = 1; i < 4 && i < wt0.size(); i++) begin
      n_cmp++;
      if (wt0[i] - wt0[i-1] !== 32) begin n_bad++; $display("FAIL strobe_gap%0d: got %0d want 32", i, wt0[i] - wt0[i-1]); end
    end
    n_cmp++;
    if (cs_lo0 !== 258) begin n_bad++; $display("FAIL cs_low: got %0d want 258", cs_lo0); end
    n_cmp++;
    if (done_n0 !== 1 || ovl0 !== 0) begin n_bad++; $display("FAIL done_pulse: got %0d pulses %0d overlaps want 1/0", done_n0, ovl0); end
  endtask

  task automatic test_zero_len();
    clear_mon();
    pulse(0, 24'h000100, 16'd0);
    n_cmp++;
    if ({done0, busy0} !== 2'b10) begin n_bad++; $display("FAIL zero_done_t1: got %b want 10", {done0, busy0}); end
    @(negedge clk_in);
    n_cmp++;
    if (done0 !== 1'b0) begin n_bad++; $display("FAIL zero_done_t2: got %b want 0", done0); end
    repeat (10) @(negedge clk_in);
    n_cmp++;
    if (cs_lo0 !== 0 || sclk_hi0 !== 0 || wa0.size() !== 0 || done_n0 !== 1) begin
      n_bad++; $display("FAIL zero_quiet: got cs %0d sclk %0d we %0d done %0d want 0/0/0/1", cs_lo0, sclk_hi0, wa0.size(), done_n0);
    end
  endtask

  task automatic test_ignored_start();
    clear_mon();
    pulse(0, 24'h0ABCDE, 16'd2);
    repeat (60) @(negedge clk_in);
    flash_addr = 24'h777777;
    byte_len   = 16'd5;
    start0     = 1'b1;
    @(negedge clk_in);
    start0 = 1'b0;
    wait_done(0, 2000);
    n_cmp++;
    if (mosi_cap0 !== 32'h030ABCDE) begin n_bad++; $display("FAIL ign_hdr: got %h want 030ABCDE", mosi_cap0); end
    n_cmp++;
    if (wa0.size() !== 2 || cs_lo0 !== 194 || done_n0 !== 1) begin
      n_bad++; $display("FAIL ign_len: got we %0d cs %0d done %0d want 2/194/1", wa0.size(), cs_lo0, done_n0);
    end
    n_cmp++;
    if (wd0.size() >= 2 && (wd0[0] !== 8'hA5 || wd0[1] !== 8'h5A)) begin
      n_bad++; $display("FAIL ign_data: got %h %h want A5 5A", wd0[0], wd0[1]);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    clear_mon();
    pulse(0, 24'h000000, 16'd4);
    k = 0;
    while (wa0.size() < 1 && k < 500) begin @(negedge clk_in); k++; end
    repeat (10) @(negedge clk_in);
    rst = 1'b1;
    @(negedge clk_in);
    n_cmp++;
    if ({CS0, SCLK0, busy0, mem_we0, done0} !== 5'b10000 || mem_addr0 !== 10'd0) begin
      n_bad++; $display("FAIL rst_mid: got %b addr %0d want 10000 addr 0", {CS0, SCLK0, busy0, mem_we0, done0}, mem_addr0);
    end
    rst = 1'b0;
    repeat (400) @(negedge clk_in);
    n_cmp++;
    if (wa0.size() !== 1 || done_n0 !== 0) begin
      n_bad++; $display("FAIL rst_quiet: got we %0d done %0d want 1/0", wa0.size(), done_n0);
    end
    clear_mon();
    pulse(0, 24'h000010, 16'd1);
    wait_done(0, 1000);
    n_cmp++;
    if (mosi_cap0 !== 32'h03000010 || wa0.size() !== 1 || done_n0 !== 1) begin
      n_bad++; $display("FAIL rst_rerun: got hdr %h we %0d done %0d want 03000010/1/1", mosi_cap0, wa0.size(), done_n0);
    end
    n_cmp++;
    if (wa0.size() >= 1 && (wa0[0] !== 0 || wd0[0] !== 8'hA5)) begin
      n_bad++; $display("FAIL rst_rerun_data: got (%0d,%h) want (0,A5)", wa0[0], wd0[0]);
    end
  endtask

  task automatic test_div1();
    fbytes[0] = 8'hC3;
    clear_mon();
    pulse(1, 24'h000040, 16'd1);
    wait_done(1, 500);
    n_cmp++;
    if (cs_lo1 !== 81 || sclk_hi1 !== 40) begin
      n_bad++; $display("FAIL div1_timing: got cs %0d sclk_hi %0d want 81/40", cs_lo1, sclk_hi1);
    end
    n_cmp++;
    if (mosi_cap1 !== 32'h03000040) begin n_bad++; $display("FAIL div1_hdr: got %h want 03000040", mosi_cap1); end
    n_cmp++;
    if (wa1.size() !== 1 || done_n1 !== 1 || ovl1 !== 0) begin
      n_bad++; $display("FAIL div1_cnt: got we %0d done %0d ovl %0d want 1/1/0", wa1.size(), done_n1, ovl1);
    end
    n_cmp++;
    if (wa1.size() >= 1 && (wa1[0] !== 0 || wd1[0] !== 8'hC3)) begin
      n_bad++; $display("FAIL div1_data: got (%0d,%h) want (0,C3)", wa1[0], wd1[0]);
    end
  endtask

  task automatic test_addr_wrap();
    int exp_a [5];
    exp_a = '{0, 1, 2, 3, 0};
    fbytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00, 8'h00, 8'h00};
    clear_mon();
    pulse(1, 24'h000200, 16'd5);
    wait_done(1, 1000);
    n_cmp++;
    if (wa1.size() !== 5 || cs_lo1 !== 145) begin
      n_bad++; $display("FAIL wrap_cnt: got we %0d cs %0d want 5/145", wa1.size(), cs_lo1);
    end
    for (int i = 0; i < 5 && i < wa1.size(); i++) begin
      n_cmp++;
      if (wa1[i] !== exp_a[i] || wd1[i] !== fbytes[i]) begin
        n_bad++; $display("FAIL wrap%0d: got (%0d,%h) want (%0d,%h)", i, wa1[i], wd1[i], exp_a[i], fbytes[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_main_read();
    test_zero_len();
    test_ignored_start();
    test_reset_mid();
    test_div1();
    test_addr_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
